// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth signed multiplier, one digit per clock. Defining BOOTH_APPROX_EN drops the low APPROX_DIGITS partial products.
// Latency: WIDTH/2 cycles from the accept edge to out_valid. The minimum initiation interval is WIDTH/2+2 cycles.
// Backpressure: the result holds in DONE until out_ready. in_ready is low whenever an operation is in flight.
module booth_r4_seq_mult #(
    parameter int WIDTH         = 8,
    parameter int APPROX_DIGITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N     = WIDTH / 2;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

`ifdef BOOTH_APPROX_EN
    localparam int DROP_DIGITS = APPROX_DIGITS;
`else
    localparam int DROP_DIGITS = 0 * APPROX_DIGITS;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH:0]     mplr_q,  mplr_d;
    logic [PW-1:0]      acc_q,   acc_d;
    logic [CNT_W-1:0]   idx_q,   idx_d;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      mcand_x2;
    logic               drop;

    // The multiplicand is pre-shifted by 2 each digit, and the multiplier is shifted right by 2.
    // The current Booth triplet is therefore always at mplr_q[2:0].
    always_comb begin
        mcand_x2 = mcand_q << 1;
        pp       = '0;
        case (mplr_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_x2;
            3'b100:         pp = -mcand_x2;
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
        drop = (32'(idx_q) < DROP_DIGITS);
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d = {{WIDTH{a[WIDTH-1]}}, a};
                    mplr_d  = {b, 1'b0};
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d   = acc_q + (drop ? '0 : pp);
                mcand_d = mcand_q << 2;
                mplr_d  = {2'b00, mplr_q[WIDTH:2]};
                idx_d   = idx_q + 1'b1;
                if (idx_q == CNT_W'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // in_ready is gated by rst so that nothing is offered while the block is held in reset.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = acc_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult at WIDTH=8. It selects its expected values according to whether BOOTH_APPROX_EN is defined.
module tb_booth_r4_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    booth_r4_seq_mult #(.WIDTH(8), .APPROX_DIGITS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] av, input logic [7:0] bv);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd6; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({in_ready, out_valid, busy} !== 3'b000) begin
                n_miss++; $display("FAIL reset_ctrl cyc%0d got rdy/vld/busy=%b want 000", k, {in_ready, out_valid, busy});
            end
            n_vec++;
            if (product !== 16'h0000) begin
                n_miss++; $display("FAIL reset_product cyc%0d got %h want 0000", k, product);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++; $display("FAIL reset_release_rdy got %b want 1", in_ready);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++; $display("FAIL reset_no_capture busy got %b want 0", busy);
        end
    endtask

    task automatic test_exact();
        int cyc;
        accept(8'd5, 8'd6);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            n_vec++;
            if (busy !== 1'b1) begin
                n_miss++; $display("FAIL exact_busy_calc cyc%0d got %b want 1", cyc, busy);
            end
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== 4) begin
            n_miss++; $display("FAIL exact_latency got %0d want 4", cyc);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++; $display("FAIL exact_busy_done got %b want 1", busy);
        end
        n_vec++;
`ifdef BOOTH_APPROX_EN
        if (product !== 16'h0028) begin
            n_miss++; $display("FAIL exact_5x6 got %h want 0028", product);
        end
`else
        if (product !== 16'h001E) begin
            n_miss++; $display("FAIL exact_5x6 got %h want 001e", product);
        end
`endif
        release_out();
        n_vec++;
        if ({busy, out_valid, in_ready} !== 3'b001) begin
            n_miss++; $display("FAIL exact_idle got busy/vld/rdy=%b want 001", {busy, out_valid, in_ready});
        end
    endtask

    task automatic test_corners();
        logic [7:0]  av [4];
        logic [7:0]  bv [4];
        logic [15:0] ev [4];
        int cyc;
        av = '{8'h80, 8'h80, 8'hFF, 8'h00};
        bv = '{8'h80, 8'h7F, 8'hFF, 8'h80};
`ifdef BOOTH_APPROX_EN
        ev = '{16'h4000, 16'hC000, 16'h0000, 16'h0000};
`else
        ev = '{16'h4000, 16'hC080, 16'h0001, 16'h0000};
`endif
        for (int k = 0; k < 4; k++) begin
            accept(av[k], bv[k]);
            wait_valid(cyc);
            n_vec++;
            if (cyc !== 4) begin
                n_miss++; $display("FAIL corner%0d_latency got %0d want 4", k, cyc);
            end
            n_vec++;
            if (product !== ev[k]) begin
                n_miss++; $display("FAIL corner%0d_product %h*%h got %h want %h", k, av[k], bv[k], product, ev[k]);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [15:0] exp1;
        logic [15:0] exp2;
`ifdef BOOTH_APPROX_EN
        exp1 = 16'h0038; exp2 = 16'h000C;
`else
        exp1 = 16'h003F; exp2 = 16'h0009;
`endif
        accept(8'd7, 8'd9);
        wait_valid(cyc);
        in_valid = 1'b1; a = 8'd3; b = 8'd3;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if ({out_valid, in_ready} !== 2'b10 || product !== exp1) begin
                n_miss++; $display("FAIL bp_hold cyc%0d got vld/rdy=%b prod=%h want 10 %h", k, {out_valid, in_ready}, product, exp1);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_miss++; $display("FAIL bp_return_idle got vld/rdy=%b want 01", {out_valid, in_ready});
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++; $display("FAIL bp_next_accept busy got %b want 1", busy);
        end
        wait_valid(cyc);
        n_vec++;
        if (cyc !== 4 || product !== exp2) begin
            n_miss++; $display("FAIL bp_next_result got lat=%0d prod=%h want 4 %h", cyc, product, exp2);
        end
        release_out();
    endtask

    task automatic test_reset_mid_calc();
        logic seen;
        accept(8'd5, 8'd6);
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if ({busy, out_valid, in_ready} !== 3'b000) begin
            n_miss++; $display("FAIL midrst_state got busy/vld/rdy=%b want 000", {busy, out_valid, in_ready});
        end
        n_vec++;
        if (product !== 16'h0000) begin
            n_miss++; $display("FAIL midrst_product got %h want 0000", product);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0 || busy !== 1'b0) begin
            n_miss++; $display("FAIL midrst_no_result got seen=%b busy=%b want 0 0", seen, busy);
        end
    endtask

    task automatic test_approx();
        logic [7:0]  av [2];
        logic [7:0]  bv [2];
        logic [15:0] ev [2];
        int cyc;
        av = '{8'd5, 8'd3};
        bv = '{8'd6, 8'd1};
`ifdef BOOTH_APPROX_EN
        ev = '{16'h0028, 16'h0000};
`else
        ev = '{16'h001E, 16'h0003};
`endif
        for (int k = 0; k < 2; k++) begin
            accept(av[k], bv[k]);
            wait_valid(cyc);
            n_vec++;
            if (cyc !== 4) begin
                n_miss++; $display("FAIL approx%0d_latency got %0d want 4", k, cyc);
            end
            n_vec++;
            if (product !== ev[k]) begin
                n_miss++; $display("FAIL approx%0d_product got %h want %h", k, product, ev[k]);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_corners();
        test_backpressure();
        test_reset_mid_calc();
        test_approx();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
